rgb565_to_888_stream: RTL

RGB565_TO_888_STREAM -- requirements
Module: rgb565_to_888_stream

---
 rtl/rgb565_to_888_stream.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rgb565_to_888_stream.sv
// RGB565 byte-pair assembler with 5/6/5 -> 8/8/8 expansion feeding a show-ahead pixel FIFO.
// The byte source has no backpressure. A pixel that arrives while the FIFO is full is
// dropped and recorded in a sticky overflow flag.
module rgb565_to_888_stream #(
    parameter int unsigned HIGH_BYTE_FIRST = 1,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned EXPAND_MODE     = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [7:0]                    i_byte,
    input  logic                          i_byte_valid,
    input  logic                          i_sof,
    output logic [7:0]                    o_rgbdata_r,
    output logic [7:0]                    o_rgbdata_g,
    output logic [7:0]                    o_rgbdata_b,
    output logic                          o_sof,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow,
    input  logic                          i_clr_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [0:0] {StWaitFirst, StWaitSecond} state_e;

    state_e         state_q, state_d;
    logic [7:0]     hold_q, hold_d;
    logic           pend_sof_q, pend_sof_d;
    logic           push_req;

    logic [15:0]    word;
    logic [23:0]    rgb888;

    logic [24:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  level_q;
    logic           overflow_q;
    logic           full, pop, push_ok, drop;
    logic [24:0]    head;

    // Pair assembler: a byte flagged sof always restarts the pair, discarding any held byte.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pend_sof_d = pend_sof_q;
        push_req   = 1'b0;
        if (i_byte_valid) begin
            if (i_sof || state_q == StWaitFirst) begin
                hold_d     = i_byte;
                pend_sof_d = i_sof;
                state_d    = StWaitSecond;
            end else begin
                push_req = 1'b1;
                state_d  = StWaitFirst;
            end
        end
    end

    // Assembler state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StWaitFirst;
            hold_q     <= 8'h00;
            pend_sof_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pend_sof_q <= pend_sof_d;
        end
    end

    // Word assembly and channel expansion, done before the FIFO write.
    always_comb begin
        word   = (HIGH_BYTE_FIRST != 0) ? {hold_q, i_byte} : {i_byte, hold_q};
        rgb888 = '0;
        if (EXPAND_MODE != 0) begin
            rgb888 = {word[15:11], word[15:13], word[10:5], word[10:9],
                      word[4:0], word[4:2]};
        end else begin
            rgb888 = {word[15:11], 3'b000, word[10:5], 2'b00, word[4:0], 3'b000};
        end
    end

    // FIFO control: a pop in the same cycle frees the slot for a push even when full.
    always_comb begin
        full    = (level_q == LW'(FIFO_DEPTH));
        pop     = o_valid && i_ready;
        push_ok = i_rst_n && push_req && (!full || pop);
        drop    = push_req && full && !pop;
    end

    // FIFO storage; left unreset because empty-slot contents are never exposed.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {pend_sof_q, rgb888};
        end
    end

    // FIFO pointers, occupancy and sticky overflow; a new drop wins over a clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop)      level_q <= level_q + LW'(1);
            else if (!push_ok && pop) level_q <= level_q - LW'(1);
            if (drop)                 overflow_q <= 1'b1;
            else if (i_clr_overflow)  overflow_q <= 1'b0;
        end
    end

    // Show-ahead outputs, forced to zero while the FIFO is empty.
    always_comb begin
        head        = mem_q[rd_ptr_q];
        o_valid     = (level_q != '0);
        o_level     = level_q;
        o_overflow  = overflow_q;
        o_rgbdata_r = o_valid ? head[23:16] : 8'h00;
        o_rgbdata_g = o_valid ? head[15:8]  : 8'h00;
        o_rgbdata_b = o_valid ? head[7:0]   : 8'h00;
        o_sof       = o_valid ? head[24]    : 1'b0;
    end

endmodule
